// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and defaults for the IF-stage fetch controller.
// No logic; FSM encoding, PC width, reset vector, NOP word and buffer entry layout.
// No backpressure involvement.
package pc_fetch_ctrl_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [PC_W-1:0] NOP_INSTR_DEF    = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] instr;
    } fetch_ent_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_fetch_buf.sv
// 2-entry {pc, instr} buffer between instruction fetch and ID, with flush.
// Push is visible at the head the cycle after it is written; head is a plain register.
// Caller must never push into a full buffer unless it also pops; flush beats push.
module fetch_buf
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = RESET_VECTOR_DEF,
    parameter logic [PC_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push_vld,
    input  fetch_ent_t push_dat,
    input  logic       pop,
    output logic [1:0] count,
    output logic       head_vld,
    output fetch_ent_t head_dat
);

    logic [1:0] cnt_q;
    fetch_ent_t head_q;
    fetch_ent_t tail_q;

    // The head register always shows NOP once the buffer runs empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= 2'd0;
            head_q.pc    <= RESET_PC;
            head_q.instr <= NOP_INSTR;
            tail_q       <= '0;
        end else if (flush) begin
            cnt_q        <= 2'd0;
            head_q.instr <= NOP_INSTR;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (push_vld) begin
                        head_q <= push_dat;
                        cnt_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push_vld && pop) begin
                        head_q <= push_dat;
                    end else if (push_vld) begin
                        tail_q <= push_dat;
                        cnt_q  <= 2'd2;
                    end else if (pop) begin
                        head_q.instr <= NOP_INSTR;
                        cnt_q        <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (push_vld) tail_q <= push_dat;
                        else          cnt_q  <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign count    = cnt_q;
    assign head_vld = (cnt_q != 2'd0);
    assign head_dat = head_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and single-outstanding I-side fetch sequencer feeding a 2-entry ID buffer.
// Request one cycle after credit frees; response visible at if_* the cycle after rvalid.
// id_stall backpressures via buffer credit; req/addr held until gnt; rvalid never stalled.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [PC_W-1:0] NOP_INSTR    = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [PC_W-1:0] trap_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [PC_W-1:0] imem_rdata,
    output logic            if_valid,
    output logic [PC_W-1:0] if_pc,
    output logic [PC_W-1:0] if_instr
);

    fetch_state_e    state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] fetch_addr_q;
    logic            discard_q;

    logic            redir;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_nxt;
    logic            pop;
    logic            beat;
    logic            push;
    logic [1:0]      buf_cnt;
    logic [2:0]      cnt_nxt;
    logic            credit;
    logic            load_req;
    fetch_ent_t      head;

    assign redir  = trap_valid | redirect_valid;
    assign target = align_pc(trap_valid ? trap_pc : redirect_pc);
    assign pop    = if_valid & ~id_stall;
    assign beat   = (state_q == WAIT) & imem_rvalid;
    assign push   = beat & ~discard_q & ~redir;

    // Occupancy after this edge; a new request reserves the remaining slot.
    assign cnt_nxt = redir ? 3'd0 : ({1'b0, buf_cnt} + {2'b00, push} - {2'b00, pop});
    assign credit  = (cnt_nxt < 3'd2);

    assign load_req = (state_q == IDLE)
                    | (beat && credit)
                    | ((state_q == HOLD) && credit);

    // A pending discard means pc_q already holds a redirect target; gnt must not overwrite it.
    always_comb begin
        pc_nxt = pc_q;
        if (redir)
            pc_nxt = target;
        else if ((state_q == REQ) && imem_gnt && !discard_q)
            pc_nxt = fetch_addr_q + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_VECTOR;
            fetch_addr_q <= RESET_VECTOR;
            discard_q    <= 1'b0;
            imem_req     <= 1'b0;
        end else begin
            pc_q <= pc_nxt;
            case (state_q)
                REQ: begin
                    if (redir) discard_q <= 1'b1;
                    if (imem_gnt) begin
                        state_q  <= WAIT;
                        imem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        discard_q <= 1'b0;
                        if (!credit) state_q <= HOLD;
                    end else if (redir) begin
                        discard_q <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (load_req) begin
                state_q      <= REQ;
                fetch_addr_q <= pc_nxt;
                imem_req     <= 1'b1;
            end
        end
    end

    assign imem_addr = fetch_addr_q;

    fetch_buf #(
        .RESET_PC  (RESET_VECTOR),
        .NOP_INSTR (NOP_INSTR)
    ) u_fetch_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redir),
        .push_vld (push),
        .push_dat ('{pc: fetch_addr_q, instr: imem_rdata}),
        .pop      (pop),
        .count    (buf_cnt),
        .head_vld (if_valid),
        .head_dat (head)
    );

    assign if_pc    = head.pc;
    assign if_instr = head.instr;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a stream-level fetch model and a latency-programmable memory.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    pc_fetch_ctrl #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // Memory: answers each granted request exactly lat cycles after the grant.
    int          lat = 1;
    logic        pend;
    logic [31:0] paddr;
    int          pcnt;
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pend        = 1'b0;
        paddr       = '0;
        pcnt        = 0;
        forever begin
            @(negedge clk);
            if (rst_n && imem_req && imem_gnt) begin
                pend  = 1'b1;
                paddr = imem_addr;
                pcnt  = lat;
            end
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                pcnt--;
                if (pcnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = instr_of(paddr);
                    pend        = 1'b0;
                end
            end
        end
    end

    // Stream model: ID must see a contiguous +4 sequence that restarts at each redirect target,
    // and each newly issued request must continue the same sequence.
    logic [31:0] exp_pc, exp_req, prev_addr, tgt;
    logic        prev_req, prev_gnt, prev_redir;
    logic [31:0] gnt_log[$];
    logic [31:0] pop_log[$];
    initial begin
        exp_pc = RV; exp_req = RV; prev_addr = '0; tgt = '0;
        prev_req = 1'b0; prev_gnt = 1'b0; prev_redir = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_pc = RV; exp_req = RV;
                prev_req = 1'b0; prev_gnt = 1'b0; prev_redir = 1'b0;
            end else begin
                if (prev_req && !prev_gnt) begin
                    chk("req_held", {31'b0, imem_req}, 32'd1);
                    chk("addr_held", imem_addr, prev_addr);
                end
                if (imem_req) begin
                    chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
                    if (!(prev_req && !prev_gnt)) begin
                        chk("req_addr", imem_addr, exp_req);
                        exp_req = exp_req + 32'd4;
                    end
                    if (imem_gnt) gnt_log.push_back(imem_addr);
                end
                if (prev_redir) chk("flush_valid", {31'b0, if_valid}, 32'd0);
                if (!if_valid)  chk("empty_nop", if_instr, NOP);
                if (if_valid && !id_stall) begin
                    chk("pop_pc", if_pc, exp_pc);
                    chk("pop_instr", if_instr, instr_of(exp_pc));
                    pop_log.push_back(if_pc);
                    exp_pc = exp_pc + 32'd4;
                end
                if (trap_valid || redirect_valid) begin
                    tgt = (trap_valid ? trap_pc : redirect_pc) & ~32'h3;
                    exp_pc  = tgt;
                    exp_req = tgt;
                end
                prev_req   = imem_req;
                prev_gnt   = imem_gnt;
                prev_addr  = imem_addr;
                prev_redir = trap_valid || redirect_valid;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting, got no event expected event", nm);
    endtask

    task automatic wait_req();
        int i;
        for (i = 0; i < 50; i++) begin
            if (imem_req) break;
            cyc(1);
        end
        if (i == 50) timeout("wait_req");
    endtask

    task automatic wait_pops(input int n);
        int i;
        for (i = 0; i < 200; i++) begin
            if (pop_log.size() >= n) break;
            cyc(1);
        end
        if (i == 200) timeout("wait_pops");
    endtask

    task automatic redir_pop(input logic tv, input logic [31:0] tpc, input logic rv,
                             input logic [31:0] rpc, input logic [31:0] exp0, input string nm);
        int k0;
        trap_valid = tv; trap_pc = tpc; redirect_valid = rv; redirect_pc = rpc;
        cyc(1);
        trap_valid = 1'b0; redirect_valid = 1'b0;
        k0 = pop_log.size();
        wait_pops(k0 + 1);
        chk(nm, pop_log[k0], exp0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_req"},   {31'b0, imem_req}, 32'd0);
        chk({nm, "_addr"},  imem_addr, RV);
        chk({nm, "_valid"}, {31'b0, if_valid}, 32'd0);
        chk({nm, "_pc"},    if_pc, RV);
        chk({nm, "_instr"}, if_instr, NOP);
    endtask

    initial begin
        int n0, k0, s;
        logic [31:0] a0, p0;
        logic [31:0] e[4];
        rst_n = 1'b0; id_stall = 1'b0; imem_gnt = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; trap_valid = 1'b0; trap_pc = '0;
        cyc(3);
        chk_reset_vals("reset");

        // Free-running fetch from reset.
        rst_n = 1'b1;
        imem_gnt = 1'b1;
        wait_pops(4);
        e = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 4; i++) chk("boot_req", gnt_log[i], e[i]);
        for (int i = 0; i < 3; i++) chk("boot_pop", pop_log[i], e[i]);

        // Stall fills the buffer and parks the requester.
        id_stall = 1'b1;
        cyc(3);
        chk("stall_valid", {31'b0, if_valid}, 32'd1);
        p0 = if_pc;
        for (int i = 0; i < 3; i++) begin
            chk("stall_pc_held", if_pc, p0);
            cyc(1);
        end
        chk("stall_req_low", {31'b0, imem_req}, 32'd0);
        id_stall = 1'b0;
        s = pop_log.size();
        wait_pops(s + 4);
        chk("stall_resume", pop_log[s], p0);

        // Redirect while a response is outstanding.
        lat = 3;
        wait_req();
        cyc(1);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
        n0 = gnt_log.size();
        cyc(1);
        redirect_valid = 1'b0;
        chk("wait_flush", {31'b0, if_valid}, 32'd0);
        k0 = pop_log.size();
        lat = 1;
        wait_pops(k0 + 1);
        chk("wait_redir_req", gnt_log[n0], 32'h8000_0000);
        chk("wait_redir_pop", pop_log[k0], 32'h8000_0000);

        // Redirect before gnt: held request completes, then the target.
        imem_gnt = 1'b0;
        cyc(1);
        wait_req();
        a0 = imem_addr;
        n0 = gnt_log.size();
        cyc(1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        cyc(1);
        redirect_valid = 1'b0;
        k0 = pop_log.size();
        chk("pregnt_addr", imem_addr, a0);
        chk("pregnt_req", {31'b0, imem_req}, 32'd1);
        imem_gnt = 1'b1;
        wait_pops(k0 + 1);
        chk("pregnt_old", gnt_log[n0], a0);
        chk("pregnt_new", gnt_log[n0 + 1], 32'h0000_0100);
        chk("pregnt_pop", pop_log[k0], 32'h0000_0100);

        // Redirect in the same cycle as gnt.
        imem_gnt = 1'b0;
        cyc(1);
        wait_req();
        a0 = imem_addr;
        n0 = gnt_log.size();
        imem_gnt = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        cyc(1);
        redirect_valid = 1'b0;
        k0 = pop_log.size();
        wait_pops(k0 + 1);
        chk("samegnt_old", gnt_log[n0], a0);
        chk("samegnt_new", gnt_log[n0 + 1], 32'h0000_0040);
        chk("samegnt_pop", pop_log[k0], 32'h0000_0040);

        // Trap priority, alignment, and wrap.
        redir_pop(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 32'h0000_0200, "trap_wins");
        redir_pop(1'b0, 32'h0, 1'b1, 32'h0000_0103, 32'h0000_0100, "align");
        redir_pop(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "wrap_top");
        k0 = pop_log.size();
        wait_pops(k0 + 1);
        chk("wrap_zero", pop_log[k0], 32'h0000_0000);

        // Asynchronous reset in the middle of an outstanding fetch.
        redir_pop(1'b0, 32'h0, 1'b1, 32'h0000_0400, 32'h0000_0400, "pre_reset");
        lat = 3;
        wait_req();
        cyc(1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        cyc(2);
        lat = 1;
        rst_n = 1'b1;
        k0 = pop_log.size();
        wait_pops(k0 + 2);
        chk("rst_restart0", pop_log[k0], 32'h0);
        chk("rst_restart1", pop_log[k0 + 1], 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected completion");
        $fatal(1, "watchdog");
    end

endmodule
